// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: takes one miss, issues a line read,
// assembles the response beats and writes the finished line back with a one-cycle strobe.
module icache_refill #(
    parameter int XLEN   = 32,
    parameter int ICLLEN = 128,
    parameter int MEMW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [XLEN-1:0]   miss_addr,
    output logic              miss_ready,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [XLEN-1:0]   mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [MEMW-1:0]   mem_resp_data,
    output logic              fill_valid,
    output logic [XLEN-1:0]   fill_addr,
    output logic [ICLLEN-1:0] fill_data,
    output logic              busy
);

    localparam int BEATS = ICLLEN / MEMW;
    localparam int BW    = $clog2(BEATS);
    localparam int OFFW  = $clog2(ICLLEN / 8);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RESP  = 3'd2,
        DRAIN = 3'd3,
        FILL  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [XLEN-1:0]   line_addr_q, line_addr_d;
    logic [ICLLEN-1:0] line_q, line_d;
    logic              lastBeat;

    assign lastBeat = mem_resp_valid && (beat_q == BW'(BEATS - 1));

    // A flush that coincides with the final beat has nothing left to drain,
    // so it goes straight back to IDLE instead of waiting in DRAIN forever.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        line_d      = line_q;
        case (state_q)
            IDLE: begin
                if (miss_valid && !flush) begin
                    line_addr_d = {miss_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    beat_d      = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    line_d[beat_q*MEMW +: MEMW] = mem_resp_data;
                    beat_d = beat_q + 1'b1;
                end
                if (lastBeat) begin
                    state_d = flush ? IDLE : FILL;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (lastBeat) begin
                        state_d = IDLE;
                    end
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            line_q      <= line_d;
        end
    end

    assign miss_ready    = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign mem_req_valid = (state_q == REQ) && !flush;
    assign mem_req_addr  = line_addr_q;
    assign fill_valid    = (state_q == FILL);
    assign fill_addr     = line_addr_q;
    assign fill_data     = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed refill scenarios plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_icache_refill;

    localparam int BEATS = 4;

    logic         clk;
    logic         rst;
    logic         miss_valid;
    logic [31:0]  miss_addr;
    logic         miss_ready;
    logic         flush;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [31:0]  mem_resp_data;
    logic         fill_valid;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic         busy;

    int testsRun  = 0;
    int failCount = 0;
    bit checkEn   = 0;

    // Model view of one outstanding refill: accepted, request issued,
    // beats received, abandoned by flush, and a pending fill strobe.
    bit           mActive;
    bit           mIssued;
    int           mCount;
    bit           mDropped;
    bit           mFill;
    logic [31:0]  mLine;
    logic [127:0] mBuf;

    icache_refill #(.XLEN(32), .ICLLEN(128), .MEMW(32)) dut (
        .clk(clk),
        .rst(rst),
        .miss_valid(miss_valid),
        .miss_addr(miss_addr),
        .miss_ready(miss_ready),
        .flush(flush),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data),
        .fill_valid(fill_valid),
        .fill_addr(fill_addr),
        .fill_data(fill_data),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic mv, input logic [31:0] ma, input logic fl,
                                 input logic rr, input logic rv, input logic [31:0] rd);
        rst            = r;
        miss_valid     = mv;
        miss_addr      = ma;
        flush          = fl;
        mem_req_ready  = rr;
        mem_resp_valid = rv;
        mem_resp_data  = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset();
        checkOutput("rstMissReady", miss_ready, 1'b1);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstFillValid", fill_valid, 1'b0);
        checkOutput("rstFillAddr", fill_addr, 32'h0);
        checkOutput("rstFillData", fill_data, 128'h0);
    endtask

    // Beat i carries base*(i+1); flushBeat/rstBeat abort just before that beat index.
    task automatic runRefill(input logic [31:0] addr, input int reqWait, input int gap,
                             input int flushBeat, input int rstBeat, input logic [31:0] base);
        logic [31:0] la;
        logic        expFill;
        la      = addr & 32'hFFFF_FFF0;
        expFill = (flushBeat < 0) && (rstBeat < 0);
        applyStimulus(1'b0, 1'b1, addr, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, addr, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int w = 0; w < reqWait; w++) begin
            checkOutput("reqHoldValid", mem_req_valid, 1'b1);
            checkOutput("reqHoldAddr", mem_req_addr, la);
            tick();
        end
        applyStimulus(1'b0, 1'b0, addr, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < BEATS; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    applyStimulus(1'b0, 1'b0, addr, 1'b0, 1'b0, 1'b0, 32'h0);
                    tick();
                end
            end
            if (i == rstBeat) begin
                applyStimulus(1'b1, 1'b0, addr, 1'b0, 1'b0, 1'b0, 32'h0);
                tick();
                checkReset();
            end
            if (i == flushBeat) begin
                applyStimulus(1'b0, 1'b0, addr, 1'b1, 1'b0, 1'b0, 32'h0);
                tick();
            end
            checkOutput("fillEarly", fill_valid, 1'b0);
            applyStimulus(1'b0, 1'b0, addr, 1'b0, 1'b0, 1'b1, base * (i + 1));
            tick();
        end
        applyStimulus(1'b0, 1'b0, addr, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("fillStrobe", fill_valid, expFill);
        checkOutput("busyAfterLast", busy, expFill);
        tick();
        checkOutput("fillOneCycle", fill_valid, 1'b0);
        checkOutput("readyAgain", miss_ready, 1'b1);
    endtask

    // Reference model: advances one transaction step per rising edge.
    always @(posedge clk) begin
        if (rst) begin
            mActive  = 0;
            mIssued  = 0;
            mCount   = 0;
            mDropped = 0;
            mFill    = 0;
            mLine    = 32'h0;
            mBuf     = 128'h0;
        end else if (mFill) begin
            mFill = 0;
        end else if (!mActive) begin
            if (miss_valid && !flush) begin
                mActive  = 1;
                mIssued  = 0;
                mCount   = 0;
                mDropped = 0;
                mLine    = miss_addr & 32'hFFFF_FFF0;
            end
        end else if (!mIssued) begin
            if (flush) mActive = 0;
            else if (mem_req_ready) mIssued = 1;
        end else if (mem_resp_valid) begin
            if (!mDropped) mBuf[mCount*32 +: 32] = mem_resp_data;
            mDropped = mDropped || flush;
            mCount++;
            if (mCount == BEATS) begin
                mActive = 0;
                mFill   = !mDropped;
            end
        end else if (flush) begin
            mDropped = 1;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("miss_ready", miss_ready, !(mActive || mFill));
            checkOutput("busy", busy, mActive || mFill);
            checkOutput("mem_req_valid", mem_req_valid, mActive && !mIssued && !flush);
            checkOutput("mem_req_addr", mem_req_addr, mLine);
            checkOutput("fill_valid", fill_valid, mFill);
            checkOutput("fill_addr", fill_addr, mLine);
            checkOutput("fill_data", fill_data, mBuf);
        end
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkEn = 1;
        checkReset();
        checkOutput("rstReqValid", mem_req_valid, 1'b0);
        tick();

        runRefill(32'h0000_1234, 0, 0, -1, -1, 32'h1111_1111);
        checkOutput("line035", fill_data, 128'h44444444_33333333_22222222_11111111);
        checkOutput("addr035", fill_addr, 32'h0000_1230);
        checkOutput("reqAddr035", mem_req_addr, 32'h0000_1230);

        runRefill(32'h0000_ABCD, 5, 0, -1, -1, 32'h0505_0505);
        checkOutput("addr036", fill_addr, 32'h0000_ABC0);

        applyStimulus(1'b0, 1'b1, 32'h0000_7777, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("flushReqDrop", mem_req_valid, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("flushReqIdle", miss_ready, 1'b1);
        checkOutput("flushReqBusy", busy, 1'b0);
        tick();

        runRefill(32'h0000_2000, 0, 0, 2, -1, 32'h0C0C_0C0C);
        runRefill(32'h0000_3008, 0, 2, -1, -1, 32'h0101_0101);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("strayLine", fill_data, 128'h04040404_03030303_02020202_01010101);
        checkOutput("strayBusy", busy, 1'b0);

        runRefill(32'h0000_4444, 0, 0, -1, 2, 32'h0A0A_0A0A);
        runRefill(32'h0000_5550, 1, 1, -1, -1, 32'h0010_0010);
        checkOutput("line040", fill_data, 128'h00400040_00300030_00200020_00100010);

        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(199) == 0), ($urandom_range(2) == 0), $urandom,
                          ($urandom_range(11) == 0), $urandom_range(1) == 1,
                          $urandom_range(1) == 1, $urandom);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkEn = 0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 Parameter: XLEN, 32, address width in bits.
REQ-002 Parameter: ICLLEN, 128, cache line width in bits.
REQ-003 Parameter: MEMW, 32, memory response beat width in bits; BEATS = ICLLEN/MEMW SHALL be a power of two ≥2.
REQ-004 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 miss_valid  in  1  icache reports a miss needing refill.
REQ-007 miss_addr  in  XLEN  faulting fetch address.
REQ-008 miss_ready  out  1  refill engine can accept a miss.
REQ-009 flush  in  1  fetch redirect; the pending refill is no longer wanted.
REQ-010 mem_req_valid  out  1  line read request to memory.
REQ-011 mem_req_addr  out  XLEN  line-aligned request address.
REQ-012 mem_req_ready  in  1  memory accepts the request.
REQ-013 mem_resp_valid  in  1  one response beat is present.
REQ-014 mem_resp_data  in  MEMW  response beat data, lowest address first.
REQ-015 fill_valid  out  1  single-cycle line write strobe to the icache.
REQ-016 fill_addr  out  XLEN  line-aligned address of the filled line.
REQ-017 fill_data  out  ICLLEN  assembled line.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, REQ, RESP, DRAIN and FILL, encoded as a typedef enum.
REQ-020 IDLE: miss_ready=1; on miss_valid&&!flush, latch line_addr = miss_addr with the low log2(ICLLEN/8) bits zeroed, clear the beat counter, and go to REQ.
REQ-021 REQ: mem_req_valid=1 with mem_req_addr=line_addr, held stable until mem_req_ready; on the handshake go to RESP.
REQ-022 REQ with flush=1: drop mem_req_valid the same cycle and return to IDLE with no request issued; flush takes priority over a simultaneous mem_req_ready.
REQ-023 RESP: each cycle with mem_resp_valid, write mem_resp_data into line buffer bits [beat*MEMW +: MEMW] and increment beat (log2(BEATS) bits, wraps to 0).
REQ-024 RESP: on the beat with beat==BEATS-1, go to FILL; no gaps are required between beats, and idle cycles between beats SHALL be tolerated.
REQ-025 RESP with flush=1: go to DRAIN; a beat arriving in the same cycle SHALL still be counted.
REQ-026 DRAIN: count the remaining beats and discard their data; after the last beat go to IDLE with no fill; further flush has no effect.
REQ-027 FILL: fill_valid=1 for exactly one cycle with fill_addr=line_addr and fill_data=line buffer, then go to IDLE; flush in FILL SHALL NOT suppress the fill.
REQ-028 mem_resp_valid in IDLE, REQ or FILL SHALL be ignored and SHALL NOT change any state.
REQ-029 miss_ready SHALL be 0 in every non-IDLE state; only one refill is outstanding at a time.
REQ-030 fill_data and fill_addr are don't-care when fill_valid=0 but SHALL hold their last value (no glitching to X).
REQ-031 Minimum latency from miss accept to fill_valid = 1 (REQ) + BEATS (RESP) + 1 cycles, with zero-wait memory.

Reset
REQ-032 On rst: state=IDLE, beat=0, line_addr=0, line buffer=0; mem_req_valid=0, fill_valid=0, busy=0, miss_ready=1 in the cycle after the reset edge.
REQ-033 rst asserted in any state SHALL abort the refill with no fill; beats still in flight from memory then arrive in IDLE and are ignored per REQ-028.
REQ-034 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Miss at 0x0000_1234, mem_req_ready same cycle, beats 0x11111111..0x44444444 back-to-back -> mem_req_addr=0x0000_1230; fill_valid one cycle 6 cycles after accept; fill_data=0x44444444_33333333_22222222_11111111.
REQ-036 mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable for all 5 cycles; fill arrives 5 cycles later than in REQ-035.
REQ-037 flush in REQ cycle with mem_req_ready=1 -> no handshake, IDLE next cycle, miss_ready=1, no fill.
REQ-038 flush after beat 1 -> DRAIN consumes beats 2-3, fill_valid never asserts, busy drops after beat 3, next miss is accepted normally.
REQ-039 Beats with 2 idle cycles between them plus a stray mem_resp_valid in IDLE -> correct line assembled; the stray beat changes nothing.
REQ-040 rst in RESP after 2 beats -> all outputs at reset values; following miss refills a fresh line with no stale beat data.
